// File: rtl/vga_pkg.sv
// Shared timing defaults and coordinate/sync types for the 640x480@60 display path.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank;
  } sync_t;

  // Syncs are active-low and blank means "visible", so idle is {1,1,0}.
  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b0};

  function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth delay line for sync/blank qualifiers; every stage resets to RST_VAL.
module sync_delay_line
  import vga_pkg::*;
#(
  parameter int                 DEPTH   = 1,
  parameter int                 WIDTH   = $bits(sync_t),
  parameter logic [WIDTH-1:0]   RST_VAL = SYNC_IDLE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_comb
    // Zero depth stays combinational, but still reads idle for the cycle after a reset edge.
    logic in_rst_q;

    always_ff @(posedge clk_i) begin
      in_rst_q <= rst_i;
    end

    assign q_o = in_rst_q ? RST_VAL : d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Stage boundary: d_i -> stage_q[0] -> ... -> stage_q[DEPTH-1]
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_q[i] <= RST_VAL;
        end
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Pixel/line counters, sync and blank decode, and per-frame pulses for the VGA path.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int PIPE_DELAY = 1
) (
  input  logic   vga_clk,
  input  logic   Reset,
  output coord_t DrawX,
  output coord_t DrawY,
  output logic   hs,
  output logic   vs,
  output logic   blank,
  output logic   frame_start,
  output logic   vblank_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_STOP  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_STOP  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   fs_q, vt_q;
  sync_t  sync_raw;
  sync_t  sync_dly;

  always_comb begin
    x_d = x_q + coord_t'(1);
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
    end
  end

  // Stage boundary: counters and pulses; pulses decode x_d/y_d so they line up with the counters.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
      vt_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fs_q <= (x_d == '0) && (y_d == '0);
      vt_q <= (x_d == '0) && (y_d == V_VIS);
    end
  end

  always_comb begin
    sync_raw.hs    = !in_window(x_q, HS_START, HS_STOP);
    sync_raw.vs    = !in_window(y_q, VS_START, VS_STOP);
    sync_raw.blank = (x_q < H_VIS) && (y_q < V_VIS);
  end

  // Stage boundary: PIPE_DELAY registers to match downstream colour latency.
  sync_delay_line #(
    .DEPTH   (PIPE_DELAY),
    .WIDTH   ($bits(sync_t)),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_dly (
    .clk_i (vga_clk),
    .rst_i (Reset),
    .d_i   (sync_raw),
    .q_o   (sync_dly)
  );

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = sync_dly.hs;
  assign vs          = sync_dly.vs;
  assign blank       = sync_dly.blank;
  assign frame_start = fs_q;
  assign vblank_tick = vt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken 15x10 raster, with PIPE_DELAY 0, 1 and 3 side by side.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int HV = 8, HF = 2, HS = 3, HB = 2;
  localparam int VV = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int DLY [3] = '{0, 1, 3};

  logic   clk = 1'b0;
  logic   rst;
  coord_t dx [3];
  coord_t dy [3];
  logic   hs [3];
  logic   vs [3];
  logic   bl [3];
  logic   fs [3];
  logic   vt [3];

  always #20 clk = ~clk;

  vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .PIPE_DELAY(0)) u_d0 (
    .vga_clk(clk), .Reset(rst), .DrawX(dx[0]), .DrawY(dy[0]), .hs(hs[0]), .vs(vs[0]),
    .blank(bl[0]), .frame_start(fs[0]), .vblank_tick(vt[0]));

  vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .PIPE_DELAY(1)) u_d1 (
    .vga_clk(clk), .Reset(rst), .DrawX(dx[1]), .DrawY(dy[1]), .hs(hs[1]), .vs(vs[1]),
    .blank(bl[1]), .frame_start(fs[1]), .vblank_tick(vt[1]));

  vga_timing_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                   .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                   .PIPE_DELAY(3)) u_d3 (
    .vga_clk(clk), .Reset(rst), .DrawX(dx[2]), .DrawY(dy[2]), .hs(hs[2]), .vs(vs[2]),
    .blank(bl[2]), .frame_start(fs[2]), .vblank_tick(vt[2]));

  typedef struct {
    int   x;
    int   y;
    logic hs;
    logic vs;
    logic bl;
    logic fs;
    logic vt;
  } vec_t;

  int         tests = 0;
  int         fails = 0;
  int         mx, my;
  bit         rst_state;
  logic [2:0] q [3][$];
  vec_t       tbl [15];

  function automatic void chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (model at %0d,%0d)", name, act, exp, mx, my);
    end
  endfunction

  function automatic logic [2:0] dec(int x, int y);
    logic h, v, b;
    h = !((x >= HV + HF) && (x < HV + HF + HS));
    v = !((y >= VV + VF) && (y < VV + VF + VS));
    b = (x < HV) && (y < VV);
    return {h, v, b};
  endfunction

  // Scoreboard: each cycle the decode of the model counters is queued per DUT,
  // and the entry queued PIPE_DELAY cycles earlier is what that DUT must show now.
  task automatic check();
    for (int i = 0; i < 3; i++) begin
      logic [2:0] e;
      logic [2:0] a;
      a = {hs[i], vs[i], bl[i]};
      chk($sformatf("DrawX d%0d", DLY[i]), int'(dx[i]), mx);
      chk($sformatf("DrawY d%0d", DLY[i]), int'(dy[i]), my);
      chk($sformatf("frame_start d%0d", DLY[i]), int'(fs[i]),
          (!rst_state && mx == 0 && my == 0) ? 1 : 0);
      chk($sformatf("vblank_tick d%0d", DLY[i]), int'(vt[i]),
          (!rst_state && mx == 0 && my == VV) ? 1 : 0);
      if (rst_state) begin
        q[i].delete();
        for (int k = 0; k < DLY[i]; k++) q[i].push_back(3'b110);
      end
      q[i].push_back(dec(mx, my));
      e = q[i].pop_front();
      if (rst_state) e = 3'b110;
      chk($sformatf("hs/vs/blank d%0d", DLY[i]), int'(a), int'(e));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      mx = 0;
      my = 0;
      rst_state = 1'b1;
    end else begin
      rst_state = 1'b0;
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    @(negedge clk);
    check();
  endtask

  task automatic goto_xy(int x, int y);
    int n;
    n = 0;
    while (!(mx == x && my == y && !rst_state) && n < 2 * HT * VT) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n, len, per, c_hs, c_vs, c_bl, c_bl0, c_bl3, c_fs, c_vt;

    // Expected PIPE_DELAY=1 outputs at chosen raster points: {x, y, hs, vs, blank, fs, vt}
    tbl[0]  = '{0,  0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{8,  0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{9,  0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{10, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{11, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{13, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{14, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{5,  3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{0,  6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1,  6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{0,  7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1,  7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{0,  9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1,  9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    mx = 0;
    my = 0;
    rst_state = 1'b1;
    repeat (5) step();
    chk("reset hs", int'(hs[1]), 1);
    chk("reset blank", int'(bl[1]), 0);

    rst = 1'b0;
    step();
    chk("release DrawX", int'(dx[1]), 1);
    chk("release DrawY", int'(dy[1]), 0);
    chk("blank rises after (0,0) d1", int'(bl[1]), 1);
    chk("blank still idle d3", int'(bl[2]), 0);

    n = 0;
    while (fs[1] !== 1'b1 && n < 2 * HT * VT) begin
      step();
      n++;
    end
    chk("first frame_start delay", n, HT * VT - 1);

    c_hs = 0; c_vs = 0; c_bl = 0; c_bl0 = 0; c_bl3 = 0; c_fs = 0; c_vt = 0;
    for (int k = 0; k < HT * VT; k++) begin
      c_hs  += (hs[1] == 1'b0) ? 1 : 0;
      c_vs  += (vs[1] == 1'b0) ? 1 : 0;
      c_bl  += (bl[1] == 1'b1) ? 1 : 0;
      c_bl0 += (bl[0] == 1'b1) ? 1 : 0;
      c_bl3 += (bl[2] == 1'b1) ? 1 : 0;
      c_fs  += (fs[1] == 1'b1) ? 1 : 0;
      c_vt  += (vt[1] == 1'b1) ? 1 : 0;
      step();
    end
    chk("hs low cycles per frame", c_hs, HS * VT);
    chk("vs low cycles per frame", c_vs, VS * HT);
    chk("blank cycles per frame d1", c_bl, HV * VV);
    chk("blank cycles per frame d0", c_bl0, HV * VV);
    chk("blank cycles per frame d3", c_bl3, HV * VV);
    chk("frame_start per frame", c_fs, 1);
    chk("vblank_tick per frame", c_vt, 1);
    chk("frame period", int'(fs[1]), 1);

    n = 0;
    while (hs[1] !== 1'b0 && n < 4 * HT) begin
      step();
      n++;
    end
    chk("first hs low DrawX", int'(dx[1]), HV + HF + 1);
    len = 0;
    while (hs[1] === 1'b0 && len < 4 * HT) begin
      step();
      len++;
    end
    chk("hs low width", len, HS);
    per = len;
    while (hs[1] !== 1'b0 && per < 4 * HT) begin
      step();
      per++;
    end
    chk("line period", per, HT);

    n = 0;
    while (vs[1] !== 1'b0 && n < 2 * HT * VT) begin
      step();
      n++;
    end
    chk("first vs low DrawY", int'(dy[1]), VV + VF);
    chk("first vs low DrawX", int'(dx[1]), 1);

    for (int i = 0; i < 15; i++) begin
      goto_xy(tbl[i].x, tbl[i].y);
      chk($sformatf("tbl%0d DrawX", i), int'(dx[1]), tbl[i].x);
      chk($sformatf("tbl%0d DrawY", i), int'(dy[1]), tbl[i].y);
      chk($sformatf("tbl%0d hs", i), int'(hs[1]), int'(tbl[i].hs));
      chk($sformatf("tbl%0d vs", i), int'(vs[1]), int'(tbl[i].vs));
      chk($sformatf("tbl%0d blank", i), int'(bl[1]), int'(tbl[i].bl));
      chk($sformatf("tbl%0d frame_start", i), int'(fs[1]), int'(tbl[i].fs));
      chk($sformatf("tbl%0d vblank_tick", i), int'(vt[1]), int'(tbl[i].vt));
    end

    // One-cycle reset while inside both hsync and vsync.
    goto_xy(HV + HF + HS - 1, VV + VF);
    chk("pre-reset hs d1", int'(hs[1]), 0);
    chk("pre-reset vs d1", int'(vs[1]), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid reset hs d1", int'(hs[1]), 1);
    chk("mid reset vs d1", int'(vs[1]), 1);
    chk("mid reset blank d1", int'(bl[1]), 0);
    chk("mid reset hs d3", int'(hs[2]), 1);
    chk("mid reset vs d0", int'(vs[0]), 1);
    chk("mid reset DrawX", int'(dx[1]), 0);
    chk("mid reset DrawY", int'(dy[1]), 0);
    chk("mid reset frame_start", int'(fs[1]), 0);
    step();
    chk("post reset DrawX", int'(dx[1]), 1);
    repeat (HT * VT + 20) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
